// File: rtl/mse_gpio_pkg.sv
// Shared constants, register offsets and the address decoder for the MSE GPIO bank.
package mse_gpio_pkg;

    localparam int PORT_STRIDE = 8;

    localparam logic [2:0] OFF_DIR      = 3'd0;
    localparam logic [2:0] OFF_OUT      = 3'd1;
    localparam logic [2:0] OFF_IN       = 3'd2;
    localparam logic [2:0] OFF_RISE_EN  = 3'd3;
    localparam logic [2:0] OFF_FALL_EN  = 3'd4;
    localparam logic [2:0] OFF_IRQ_STAT = 3'd5;
    localparam logic [2:0] OFF_OUT_SET  = 3'd6;
    localparam logic [2:0] OFF_OUT_CLR  = 3'd7;

    localparam logic [7:0] ADDR_IRQ_SUM = 8'hF0;
    localparam logic [7:0] ADDR_TP_CTRL = 8'hF1;

    typedef struct packed {
        logic [4:0] port;
        logic [2:0] off;
        logic       hit;
    } reg_dec_t;

    function automatic reg_dec_t decode_addr(input logic [7:0] addr, input int nports);
        reg_dec_t d;
        d.port = 5'(addr / PORT_STRIDE);
        d.off  = 3'(addr % PORT_STRIDE);
        d.hit  = (int'(d.port) < nports);
        return d;
    endfunction

endpackage

// File: rtl/mse_gpio_port.sv
// One GPIO port: direction/output/enable registers, input synchroniser,
// edge detection and the sticky interrupt status.
module mse_gpio_port
    import mse_gpio_pkg::*;
#(
    parameter int PORT_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [2:0]        wr_off,
    input  logic [PORT_W-1:0] wdata,
    input  logic              edge_en,
    input  logic [PORT_W-1:0] pad_i,
    output logic [PORT_W-1:0] dir,
    output logic [PORT_W-1:0] out,
    output logic [PORT_W-1:0] sync_in,
    output logic [PORT_W-1:0] rise_en,
    output logic [PORT_W-1:0] fall_en,
    output logic [PORT_W-1:0] stat
);

    logic [PORT_W-1:0] dir_q, dir_d;
    logic [PORT_W-1:0] out_q, out_d;
    logic [PORT_W-1:0] rise_en_q, rise_en_d;
    logic [PORT_W-1:0] fall_en_q, fall_en_d;
    logic [PORT_W-1:0] stat_q, stat_d;
    logic [PORT_W-1:0] prev_q, prev_d;
    logic [SYNC_STAGES-1:0][PORT_W-1:0] sync_q, sync_d;
    logic [PORT_W-1:0] events;

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign dir     = dir_q;
    assign out     = out_q;
    assign rise_en = rise_en_q;
    assign fall_en = fall_en_q;
    assign stat    = stat_q;

    always_comb begin
        sync_d[0] = pad_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_in;
        events = '0;
        if (edge_en) begin
            events = (sync_in & ~prev_q & rise_en_q) | (~sync_in & prev_q & fall_en_q);
        end

        dir_d     = dir_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        stat_d    = stat_q;
        if (wr_en) begin
            case (wr_off)
                OFF_DIR:      dir_d     = wdata;
                OFF_OUT:      out_d     = wdata;
                OFF_RISE_EN:  rise_en_d = wdata;
                OFF_FALL_EN:  fall_en_d = wdata;
                OFF_IRQ_STAT: stat_d    = stat_q & ~wdata;
                OFF_OUT_SET:  out_d     = out_q | wdata;
                OFF_OUT_CLR:  out_d     = out_q & ~wdata;
                default:      ;
            endcase
        end
        // A new edge must not be lost to a simultaneous clear, so it is ORed in last.
        stat_d = stat_d | events;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            stat_q    <= '0;
            prev_q    <= '0;
            sync_q    <= '0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            stat_q    <= stat_d;
            prev_q    <= prev_d;
            sync_q    <= sync_d;
        end
    end

endmodule

// File: rtl/mse_gpio_bank.sv
// Bank of NPORTS GPIO ports on the MSE register bus: decode, read mux, warm-up and irq.
// Optional test-pattern counter enabled by defining MSE_GPIO_TESTPAT_EN.
module mse_gpio_bank
    import mse_gpio_pkg::*;
#(
    parameter int NPORTS      = 10,
    parameter int PORT_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     wr,
    input  logic                     rd,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    input  logic [NPORTS*PORT_W-1:0] port_i,
    output logic [NPORTS*PORT_W-1:0] port_o,
    output logic [NPORTS*PORT_W-1:0] port_oe,
    output logic                     irq
);

    localparam int WARM   = SYNC_STAGES + 1;
    localparam int WARM_W = $clog2(WARM + 1);

    logic [31:0]       addr_ext;
    reg_dec_t          dec;
    logic              port_hit;
    logic [PORT_W-1:0] dir_w     [NPORTS];
    logic [PORT_W-1:0] out_w     [NPORTS];
    logic [PORT_W-1:0] in_w      [NPORTS];
    logic [PORT_W-1:0] rise_en_w [NPORTS];
    logic [PORT_W-1:0] fall_en_w [NPORTS];
    logic [PORT_W-1:0] stat_w    [NPORTS];
    logic [NPORTS-1:0] stat_any;
    logic [DATA_W-1:0] rd_mux, rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic              warm_done;
    logic              tp_active;
    logic [PORT_W-1:0] tp_cnt;
    logic [DATA_W-1:0] tp_ctrl_rd;

    assign addr_ext  = 32'(address);
    assign dec       = decode_addr(addr_ext[7:0], NPORTS);
    assign port_hit  = dec.hit && (addr_ext[31:8] == 24'd0);
    assign warm_done = (warm_q == WARM_W'(WARM));
    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign irq       = |stat_any;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        logic wr_sel;
        assign wr_sel = wr && port_hit && (dec.port == 5'(p));

        mse_gpio_port #(
            .PORT_W      (PORT_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_sel),
            .wr_off  (dec.off),
            .wdata   (wdata[PORT_W-1:0]),
            .edge_en (warm_done),
            .pad_i   (port_i[p*PORT_W +: PORT_W]),
            .dir     (dir_w[p]),
            .out     (out_w[p]),
            .sync_in (in_w[p]),
            .rise_en (rise_en_w[p]),
            .fall_en (fall_en_w[p]),
            .stat    (stat_w[p])
        );

        assign port_oe[p*PORT_W +: PORT_W] = dir_w[p];
        assign port_o[p*PORT_W +: PORT_W]  = tp_active ? tp_cnt : out_w[p];
        assign stat_any[p]                 = |stat_w[p];
    end

    if (DATA_W > PORT_W) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^wdata[DATA_W-1:PORT_W];
    end

`ifdef MSE_GPIO_TESTPAT_EN
    logic              tp_en_q, tp_en_d;
    logic [PORT_W-1:0] tp_cnt_q, tp_cnt_d;

    always_comb begin
        tp_en_d = tp_en_q;
        if (wr && addr_ext == 32'(ADDR_TP_CTRL)) begin
            tp_en_d = wdata[0];
        end
        tp_cnt_d = tp_en_q ? tp_cnt_q + PORT_W'(1) : tp_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tp_en_q  <= 1'b0;
            tp_cnt_q <= '0;
        end else begin
            tp_en_q  <= tp_en_d;
            tp_cnt_q <= tp_cnt_d;
        end
    end

    assign tp_active  = tp_en_q;
    assign tp_cnt     = tp_cnt_q;
    assign tp_ctrl_rd = DATA_W'(tp_en_q);
`else
    assign tp_active  = 1'b0;
    assign tp_cnt     = '0;
    assign tp_ctrl_rd = '0;
`endif

    // Read mux sees only current register state, so a same-cycle write returns the old value.
    always_comb begin
        rd_mux = '0;
        if (port_hit) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (dec.port == 5'(p)) begin
                    case (dec.off)
                        OFF_DIR:      rd_mux = DATA_W'(dir_w[p]);
                        OFF_OUT:      rd_mux = DATA_W'(out_w[p]);
                        OFF_IN:       rd_mux = DATA_W'(in_w[p]);
                        OFF_RISE_EN:  rd_mux = DATA_W'(rise_en_w[p]);
                        OFF_FALL_EN:  rd_mux = DATA_W'(fall_en_w[p]);
                        OFF_IRQ_STAT: rd_mux = DATA_W'(stat_w[p]);
                        default:      rd_mux = '0;
                    endcase
                end
            end
        end else if (addr_ext == 32'(ADDR_IRQ_SUM)) begin
            rd_mux = DATA_W'(stat_any);
        end else if (addr_ext == 32'(ADDR_TP_CTRL)) begin
            rd_mux = tp_ctrl_rd;
        end
        rdata_d  = rd ? rd_mux : rdata_q;
        rvalid_d = rd;
        warm_d   = warm_done ? warm_q : warm_q + WARM_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            warm_q   <= '0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            warm_q   <= warm_d;
        end
    end

endmodule

// File: tb/tb_mse_gpio_bank.sv
// Scoreboard testbench for mse_gpio_bank: directed bus accesses, reads checked by a monitor.
module tb_mse_gpio_bank;

    localparam int NPORTS      = 10;
    localparam int PORT_W      = 8;
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 16;
    localparam int SYNC_STAGES = 2;
    localparam int VW          = NPORTS * PORT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              wr = 1'b0;
    logic              rd = 1'b0;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic [VW-1:0]     port_i = '0;
    logic [VW-1:0]     port_o;
    logic [VW-1:0]     port_oe;
    logic              irq;

    string             name_q[$];
    logic [DATA_W-1:0] data_q[$];
    int                n_compared = 0;
    int                n_mismatched = 0;

    mse_gpio_bank #(
        .NPORTS      (NPORTS),
        .PORT_W      (PORT_W),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .address (address),
        .wdata   (wdata),
        .wr      (wr),
        .rd      (rd),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .port_i  (port_i),
        .port_o  (port_o),
        .port_oe (port_oe),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [VW-1:0] actual, input logic [VW-1:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Called at a negedge; drives one bus cycle and returns at the following negedge.
    task automatic applyStimulus(input logic [7:0] addr, input logic [15:0] data,
                                 input logic do_wr, input logic do_rd,
                                 input logic [15:0] exp_rd, input string name);
        address = addr;
        wdata   = data;
        wr      = do_wr;
        rd      = do_rd;
        if (do_rd) begin
            name_q.push_back(name);
            data_q.push_back(exp_rd);
        end
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic busWrite(input logic [7:0] addr, input logic [15:0] data);
        applyStimulus(addr, data, 1'b1, 1'b0, 16'h0, "");
    endtask

    task automatic busRead(input logic [7:0] addr, input logic [15:0] exp_rd, input string name);
        applyStimulus(addr, 16'h0, 1'b0, 1'b1, exp_rd, name);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every rvalid pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rvalid) begin
            if (data_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_rvalid: got rdata %0h, expected no read response", rdata);
            end else begin
                checkOutput(name_q.pop_front(), VW'(rdata), VW'(data_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Pads high through reset, rising edges enabled right after: warm-up must hide them.
        port_i = '1;
        @(negedge clk);
        doReset();
        busWrite(8'h03, 16'h00FF);
        repeat (6) @(negedge clk);
        checkOutput("warmup_irq", VW'(irq), VW'(0));
        busRead(8'h05, 16'h0000, "warmup_stat");
        busRead(8'h02, 16'h00FF, "in_all_ones");

        port_i = '0;
        doReset();
        checkOutput("reset_port_oe", port_oe, '0);
        checkOutput("reset_port_o", port_o, '0);
        checkOutput("reset_irq", VW'(irq), VW'(0));
        checkOutput("reset_rvalid", VW'(rvalid), VW'(0));
        checkOutput("reset_rdata", VW'(rdata), VW'(0));
        for (int a = 0; a < NPORTS * 8; a++) begin
            busRead(8'(a), 16'h0000, $sformatf("reset_reg_%0h", a));
        end

        busWrite(8'h18, 16'h00F0);
        busWrite(8'h19, 16'hFFAA);
        checkOutput("dir3_oe", port_oe, VW'(8'hF0) << 24);
        checkOutput("out3_o", port_o, VW'(8'hAA) << 24);
        busWrite(8'h1E, 16'h0005);
        checkOutput("out_set", port_o, VW'(8'hAF) << 24);
        busWrite(8'h1F, 16'h000A);
        checkOutput("out_clr", port_o, VW'(8'hA5) << 24);
        busRead(8'h19, 16'h00A5, "read_out3");
        busRead(8'h1E, 16'h0000, "read_out_set");
        busRead(8'h18, 16'h00F0, "read_dir3");

        busWrite(8'h03, 16'h0001);
        port_i[0] = 1'b1;
        port_i[9] = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("irq_before_sync", VW'(irq), VW'(0));
        @(negedge clk);
        checkOutput("irq_rise", VW'(irq), VW'(1));
        busRead(8'h05, 16'h0001, "stat_rise");
        busRead(8'h0D, 16'h0000, "stat_port1_disabled");
        busRead(8'hF0, 16'h0001, "irq_sum");
        busRead(8'h02, 16'h0001, "in_port0");
        busWrite(8'h05, 16'h0001);
        checkOutput("irq_w1c", VW'(irq), VW'(0));

        busWrite(8'h04, 16'h0001);
        port_i[0] = 1'b0;
        repeat (2) @(negedge clk);
        busWrite(8'h05, 16'h0001);
        checkOutput("set_wins_irq", VW'(irq), VW'(1));
        busRead(8'h05, 16'h0001, "set_wins_stat");
        busWrite(8'h05, 16'h0001);
        checkOutput("irq_cleared", VW'(irq), VW'(0));

        busRead(8'hC0, 16'h0000, "unmapped_rd");
        busWrite(8'hC0, 16'hFFFF);
        checkOutput("unmapped_wr_oe", port_oe, VW'(8'hF0) << 24);
        checkOutput("unmapped_wr_o", port_o, VW'(8'hA5) << 24);
        busRead(8'h18, 16'h00F0, "unmapped_wr_dir3");
        applyStimulus(8'h19, 16'h003C, 1'b1, 1'b1, 16'h00A5, "wr_rd_old");
        busRead(8'h19, 16'h003C, "wr_rd_new");
        checkOutput("wr_rd_o", port_o, VW'(8'h3C) << 24);

`ifdef MSE_GPIO_TESTPAT_EN
        busWrite(8'h48, 16'h00FF);
        busWrite(8'hF1, 16'h0001);
        busRead(8'hF1, 16'h0001, "tp_ctrl_on");
        begin
            logic [7:0] prev_v;
            logic [7:0] cur_v;
            prev_v = port_o[72 +: 8];
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                cur_v = port_o[72 +: 8];
                checkOutput("tp_step", VW'(cur_v), VW'(8'(prev_v + 8'd1)));
                prev_v = cur_v;
            end
        end
        busWrite(8'hF1, 16'h0000);
        checkOutput("tp_off_port9", VW'(port_o[72 +: 8]), VW'(0));
        checkOutput("tp_off_port3", VW'(port_o[24 +: 8]), VW'(8'h3C));
`else
        busRead(8'hF1, 16'h0000, "tp_ctrl_absent");
        busWrite(8'hF1, 16'h0001);
        busRead(8'hF1, 16'h0000, "tp_ctrl_ignored");
        checkOutput("tp_absent_o", port_o, VW'(8'h3C) << 24);
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", VW'(data_q.size()), VW'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
